// File: rtl/data_mem_if.sv
// Load/store request bus between the core's memory stage and the data-memory responder.
interface data_mem_if #(
  parameter int unsigned ADDR_WIDTH = 10
);
  logic                  MemRead;
  logic                  MemWrite;
  logic [2:0]            Funct3;
  logic [ADDR_WIDTH-1:0] Address;
  logic [31:0]           WriteData;
  logic [31:0]           ReadData;
  logic                  Ready;
  logic                  Error;
  logic                  Busy;

  modport master (
    output MemRead, MemWrite, Funct3, Address, WriteData,
    input  ReadData, Ready, Error, Busy
  );

  modport slave (
    input  MemRead, MemWrite, Funct3, Address, WriteData,
    output ReadData, Ready, Error, Busy
  );
endinterface

// File: rtl/data_mem_responder.sv
// Byte-addressable little-endian data memory with configurable wait states,
// B/H/W loads and stores, sign/zero extension and a one-cycle Ready pulse.
//
// state   | meaning
// IDLE    | waiting for MemRead/MemWrite; legal zero-wait accesses complete from here
// WAIT    | counting wait states on latched operands
// RESP    | Ready pulse (Error if rejected); request inputs ignored
module data_mem_responder #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WAIT_STATES = 1
) (
  input logic       clk,
  input logic       rst_n,
  data_mem_if.slave bus
);
  localparam int unsigned WORDS     = 2 ** (ADDR_WIDTH - 2);
  localparam logic [3:0]  WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]            state;
  logic [3:0]            cnt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [2:0]            f3_q;
  logic [31:0]           wd_q;
  logic                  wr_q;
  logic                  err_q;
  logic [31:0]           rdata_q;

  logic [31:0] mem [WORDS];

  logic                  req, f3_ok, aligned, req_legal, from_idle, do_access;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [2:0]            acc_f3;
  logic [31:0]           acc_wd;
  logic                  acc_wr;
  logic [31:0]           rd_word, load_val, wrep;
  logic [7:0]            rd_byte;
  logic [15:0]           rd_half;
  logic [3:0]            be;

  always_comb begin
    req = bus.MemRead | bus.MemWrite;
    if (bus.MemWrite)
      f3_ok = bus.Funct3 inside {3'b000, 3'b001, 3'b010};
    else
      f3_ok = bus.Funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    case (bus.Funct3[1:0])
      2'b01:   aligned = ~bus.Address[0];
      2'b10:   aligned = (bus.Address[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase
    req_legal = ~(bus.MemRead & bus.MemWrite) & f3_ok & aligned;
  end

  // Zero-wait accesses complete straight from IDLE, so use live operands there.
  always_comb begin
    from_idle = (state == ST_IDLE);
    acc_addr  = from_idle ? bus.Address   : addr_q;
    acc_f3    = from_idle ? bus.Funct3    : f3_q;
    acc_wd    = from_idle ? bus.WriteData : wd_q;
    acc_wr    = from_idle ? bus.MemWrite  : wr_q;
    do_access = (from_idle && req && req_legal && (WAIT_STATES == 0)) ||
                ((state == ST_WAIT) && (cnt == 4'd0));
  end

  always_comb begin
    rd_word = mem[acc_addr[ADDR_WIDTH-1:2]];
    rd_byte = rd_word[8*acc_addr[1:0] +: 8];
    rd_half = acc_addr[1] ? rd_word[31:16] : rd_word[15:0];
    case (acc_f3)
      3'b000:  load_val = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  load_val = {{16{rd_half[15]}}, rd_half};
      3'b100:  load_val = {24'd0, rd_byte};
      3'b101:  load_val = {16'd0, rd_half};
      default: load_val = rd_word;
    endcase
    case (acc_f3[1:0])
      2'b00: begin
        be   = 4'b0001 << acc_addr[1:0];
        wrep = {4{acc_wd[7:0]}};
      end
      2'b01: begin
        be   = acc_addr[1] ? 4'b1100 : 4'b0011;
        wrep = {2{acc_wd[15:0]}};
      end
      default: begin
        be   = 4'b1111;
        wrep = acc_wd;
      end
    endcase
  end

  // Gated by rst_n so a store caught by reset never lands.
  always_ff @(posedge clk) begin
    if (do_access && acc_wr && rst_n) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[acc_addr[ADDR_WIDTH-1:2]][8*i +: 8] <= wrep[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= 4'd0;
      addr_q  <= '0;
      f3_q    <= 3'd0;
      wd_q    <= 32'd0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req) begin
            addr_q <= bus.Address;
            f3_q   <= bus.Funct3;
            wd_q   <= bus.WriteData;
            wr_q   <= bus.MemWrite;
            err_q  <= ~req_legal;
            if (!req_legal || (WAIT_STATES == 0)) begin
              state <= ST_RESP;
            end else begin
              state <= ST_WAIT;
              cnt   <= WAIT_LOAD;
            end
          end
        end
        ST_WAIT: begin
          if (cnt == 4'd0) state <= ST_RESP;
          else             cnt   <= cnt - 4'd1;
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
      if (do_access && !acc_wr) rdata_q <= load_val;
    end
  end

  assign bus.ReadData = rdata_q;
  assign bus.Ready    = (state == ST_RESP);
  assign bus.Error    = (state == ST_RESP) & err_q;
  assign bus.Busy     = (from_idle & req) | (state == ST_WAIT);
endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Data-memory responder for the RISC-V datapath: it services the load/store requests the main control unit raises on `MemRead`/`MemWrite`. It holds a byte-addressable, little-endian local memory with a configurable number of wait states. Byte, halfword and word accesses are selected by the instruction's `funct3`. It returns sign- or zero-extended load data with a one-cycle `Ready` pulse and drives `Busy` so the core can stall while an access is in flight.

## Interface
- `ADDR_WIDTH`, default 10: byte-address width; memory size is 2^ADDR_WIDTH bytes, organised as 2^(ADDR_WIDTH-2) 32-bit words.
- `WAIT_STATES`, default 1: extra cycles inserted before each aligned access; legal range 0..15.
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `MemRead`, input, 1: load request.
- `MemWrite`, input, 1: store request.
- `Funct3`, input, 3: access size and extension.
  - 000 = B, 001 = H, 010 = W, 100 = BU, 101 = HU.
  - Stores accept only 000, 001 and 010.
- `Address`, input, ADDR_WIDTH: byte address (ALU result).
- `WriteData`, input, 32: store data; the low byte or halfword is used for SB/SH.
- `ReadData`, output, 32: extended load result.
- `Ready`, output, 1: one-cycle completion pulse.
- `Error`, output, 1: qualifies `Ready`; the access was rejected.
- `Busy`, output, 1: stall request to the core.

## Operation
- States: IDLE, WAIT, RESP.
- IDLE, no request: stay in IDLE.
- IDLE, request (`MemRead` or `MemWrite` high): latch `Address`, `Funct3`, `WriteData` and the direction.
  - Request legal and aligned: go to WAIT if `WAIT_STATES` > 0, otherwise perform the access and go to RESP.
  - Request illegal: go straight to RESP with the error flag set; memory is untouched.
- Illegal requests:
  - `MemRead` and `MemWrite` both high.
  - Undefined `Funct3` for the direction (load 011/110/111; store anything other than 000/001/010).
  - Halfword with `Address[0]` = 1.
  - Word with `Address[1:0]` != 00.
- WAIT: a 4-bit counter loads `WAIT_STATES-1` on entry and decrements each cycle. When the counter reaches 0, perform the access and go to RESP.
- Access, performed on the edge entering RESP:
  - Store: write only the addressed byte lanes (SB: 1 lane, SH: 2 lanes, SW: 4 lanes).
  - Load: register the extracted, extended value into `ReadData`.
    - B/H sign-extend from bit 7/15.
    - BU/HU zero-extend.
- RESP: `Ready` = 1 for exactly one cycle; `Error` = latched error flag. Always returns to IDLE next cycle.
- `ReadData` is updated only by successful loads. It holds its value through stores, errors and idle cycles.
- Memory array contents are not reset; they are undefined until written.
- `Busy` is combinational: (IDLE and request) or WAIT. It is 0 in RESP and when idle.
- Requester protocol:
  - Hold the request and its operands stable while `Busy` = 1.
  - Requests are not sampled in RESP.
  - A request still high in the cycle after `Ready` is treated as a new access.

## Timing
- Request first visible in cycle 0 (IDLE):
  - Legal access: `Ready` high in cycle 1+`WAIT_STATES`; `Busy` high in cycles 0..`WAIT_STATES`.
  - Illegal access: `Ready` = `Error` = 1 in cycle 1 regardless of `WAIT_STATES`.
- Load data valid in the `Ready` cycle and held afterwards.
- Store: memory updated at the edge that starts the `Ready` cycle; a load issued afterwards sees the new data.
- Back-to-back accesses: minimum issue interval is 2+`WAIT_STATES` cycles (RESP is a dead cycle).
- Reset (`rst_n` low, asynchronous, any state):
  - State = IDLE, counter = 0, `Ready` = 0, `Error` = 0, `ReadData` = 0.
  - `Busy` follows the request inputs.
  - A store still in WAIT is aborted and memory is unchanged.

## Test plan
- `WAIT_STATES` = 2: SW 0xDEADBEEF @0x010, then LW @0x010.
  - Each access: `Busy` high cycles 0–2, `Ready` high cycle 3.
  - LW returns 0xDEADBEEF.
- SB 0x80 @0x013 over word 0x00000000, then:
  - LB @0x013 → 0xFFFFFF80.
  - LBU @0x013 → 0x00000080.
  - LW @0x010 → 0x80000000.
- SH 0x8001 @0x022, then:
  - LH @0x022 → 0xFFFF8001.
  - LHU @0x022 → 0x00008001.
  - LW @0x020 → 0x80010000 (lower half untouched).
- Error cases, each → `Ready` = `Error` = 1 in cycle 1, memory unchanged, `ReadData` unchanged:
  - LW @0x002.
  - SH @0x031.
  - `Funct3` = 011 load.
  - `MemRead` = `MemWrite` = 1.
- `WAIT_STATES` = 3: SW 0x12345678 @0x040 over old data 0xAAAAAAAA; drop `rst_n` in cycle 2 for one cycle.
  - All outputs read zero, state returns to IDLE.
  - Subsequent LW @0x040 returns 0xAAAAAAAA.
- `WAIT_STATES` = 0: hold LW @0x010 high for 4 cycles.
  - `Ready` in cycles 1 and 3; RESP cycles 1 and 3 do not sample the request.
  - `Busy` = 1, 0, 1, 0.
